// File: rtl/class_hv_pkg.sv
// Shared types and default dimensions for the class hypervector bank.
package class_hv_pkg;

  localparam int NUM_CLASSES      = 10;
  localparam int SEQ_CYCLE_COUNT  = 10;
  localparam int DIMS_PER_CC      = 500;
  localparam int BITWIDTH_PER_DIM = 9;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_ADD   = 2'd2,
    OP_SUB   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

  typedef logic [DIMS_PER_CC-1:0][BITWIDTH_PER_DIM-1:0] chunk_t;

endpackage

// File: rtl/class_hv_bank_if.sv
// Command, input-chunk and output-chunk handshakes of the class HV bank.
interface class_hv_bank_if
  import class_hv_pkg::*;
#(
  parameter int NUM_CLASSES      = class_hv_pkg::NUM_CLASSES,
  parameter int SEQ_CYCLE_COUNT  = class_hv_pkg::SEQ_CYCLE_COUNT,
  parameter int DIMS_PER_CC      = class_hv_pkg::DIMS_PER_CC,
  parameter int BITWIDTH_PER_DIM = class_hv_pkg::BITWIDTH_PER_DIM
);
  localparam int CLASS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int CHUNK_W = (SEQ_CYCLE_COUNT > 1) ? $clog2(SEQ_CYCLE_COUNT) : 1;
  localparam int DATA_W  = DIMS_PER_CC * BITWIDTH_PER_DIM;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [CLASS_W-1:0] cmd_class;
  logic               cmd_err;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic [CHUNK_W-1:0] out_chunk;
  logic               out_last;
  logic               busy;
  logic               sat_flag;

  modport master (
    output cmd_valid, cmd_op, cmd_class, in_valid, in_data, out_ready,
    input  cmd_ready, cmd_err, in_ready, out_valid, out_data, out_chunk,
           out_last, busy, sat_flag
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_class, in_valid, in_data, out_ready,
    output cmd_ready, cmd_err, in_ready, out_valid, out_data, out_chunk,
           out_last, busy, sat_flag
  );

endinterface

// File: rtl/sat_addsub_vec.sv
// Per-dim signed saturating add/subtract of two chunks.
module sat_addsub_vec #(
  parameter int DIMS = 500,
  parameter int BW   = 9
) (
  input  logic [DIMS-1:0][BW-1:0] a,
  input  logic [DIMS-1:0][BW-1:0] b,
  input  logic                    sub,
  output logic [DIMS-1:0][BW-1:0] result,
  output logic                    any_sat
);
  localparam logic signed [BW:0] MAXV = {2'b00, {(BW-1){1'b1}}};
  localparam logic signed [BW:0] MINV = {2'b11, {(BW-1){1'b0}}};

  logic signed [BW:0] ea, eb, sum;

  always_comb begin
    result  = '0;
    any_sat = 1'b0;
    ea      = '0;
    eb      = '0;
    sum     = '0;
    for (int unsigned i = 0; i < DIMS; i++) begin
      ea  = {a[i][BW-1], a[i]};
      eb  = {b[i][BW-1], b[i]};
      sum = sub ? (ea - eb) : (ea + eb);
      if (sum > MAXV) begin
        result[i] = MAXV[BW-1:0];
        any_sat   = 1'b1;
      end else if (sum < MINV) begin
        result[i] = MINV[BW-1:0];
        any_sat   = 1'b1;
      end else begin
        result[i] = sum[BW-1:0];
      end
    end
  end

endmodule

// File: rtl/class_hv_bank.sv
// Chunked multi-class HV storage with streamed read, overwrite and saturating add/sub.
module class_hv_bank
  import class_hv_pkg::*;
#(
  parameter int NUM_CLASSES      = class_hv_pkg::NUM_CLASSES,
  parameter int SEQ_CYCLE_COUNT  = class_hv_pkg::SEQ_CYCLE_COUNT,
  parameter int DIMS_PER_CC      = class_hv_pkg::DIMS_PER_CC,
  parameter int BITWIDTH_PER_DIM = class_hv_pkg::BITWIDTH_PER_DIM
) (
  input logic             clk,
  input logic             nrst,
  class_hv_bank_if.slave  bus
);
  localparam int CLASS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int CHUNK_W = (SEQ_CYCLE_COUNT > 1) ? $clog2(SEQ_CYCLE_COUNT) : 1;

  typedef logic [DIMS_PER_CC-1:0][BITWIDTH_PER_DIM-1:0] vec_t;

  vec_t mem [NUM_CLASSES][SEQ_CYCLE_COUNT];

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [CLASS_W-1:0] class_q, class_d;
  logic [CHUNK_W-1:0] chunk_q, chunk_d;
  logic               sat_q, sat_d;
  logic               err_q, err_d;
  logic               wr_en;
  vec_t               cur, wr_data, arith;
  logic               arith_sat;
  logic               last;
  logic               class_ok;

  assign cur      = mem[class_q][chunk_q];
  assign last     = (chunk_q == CHUNK_W'(SEQ_CYCLE_COUNT - 1));
  assign class_ok = ({1'b0, bus.cmd_class} < (CLASS_W + 1)'(NUM_CLASSES));

  sat_addsub_vec #(
    .DIMS (DIMS_PER_CC),
    .BW   (BITWIDTH_PER_DIM)
  ) u_arith (
    .a       (cur),
    .b       (vec_t'(bus.in_data)),
    .sub     (op_q == OP_SUB),
    .result  (arith),
    .any_sat (arith_sat)
  );

  assign wr_data = (op_q == OP_WRITE) ? vec_t'(bus.in_data) : arith;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    class_d = class_q;
    chunk_d = chunk_q;
    sat_d   = sat_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          if (class_ok) begin
            op_d    = op_e'(bus.cmd_op);
            class_d = bus.cmd_class;
            chunk_d = '0;
            state_d = (op_e'(bus.cmd_op) == OP_READ) ? ST_READ : ST_UPDATE;
            if (op_e'(bus.cmd_op) == OP_ADD || op_e'(bus.cmd_op) == OP_SUB)
              sat_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (bus.out_ready) begin
          chunk_d = last ? '0 : chunk_q + CHUNK_W'(1);
          if (last) state_d = ST_IDLE;
        end
      end
      ST_UPDATE: begin
        if (bus.in_valid) begin
          wr_en   = 1'b1;
          if (op_q != OP_WRITE && arith_sat) sat_d = 1'b1;
          chunk_d = last ? '0 : chunk_q + CHUNK_W'(1);
          if (last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_READ;
      class_q <= '0;
      chunk_q <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      class_q <= class_d;
      chunk_q <= chunk_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
    end
  end

  // Reset zeroes the whole bank, so an aborted update leaves no partial data.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int unsigned c = 0; c < NUM_CLASSES; c++)
        for (int unsigned k = 0; k < SEQ_CYCLE_COUNT; k++)
          mem[c][k] <= '0;
    end else if (wr_en) begin
      mem[class_q][chunk_q] <= wr_data;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.cmd_err   = err_q;
  assign bus.in_ready  = (state_q == ST_UPDATE);
  assign bus.out_valid = (state_q == ST_READ);
  assign bus.out_data  = cur;
  assign bus.out_chunk = chunk_q;
  assign bus.out_last  = last;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.sat_flag  = sat_q;

endmodule
